// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
  localparam int UART_DATA_W     = 9;
  localparam int UART_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } uart_entry_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// Receive FIFO storage: register array, one write port, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  uart_entry_t   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output uart_entry_t   rdata_o
);

  // Contents carry no reset; occupancy tracking makes stale entries invisible.
  uart_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-detected push, show-ahead pop, sticky overrun and watermark irq.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [UART_DATA_W-1:0] data_i,
  input  logic                   rx_rdy_i,
  input  logic                   rx_err_i,
  input  logic                   clr_i,
  input  logic [AW:0]            thresh_i,
  input  logic                   rd_ready_i,
  output logic                   rd_valid_o,
  output logic [UART_DATA_W-1:0] rd_data_o,
  output logic                   rd_err_o,
  output logic [AW:0]            level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overrun_o,
  output logic                   irq_o
);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          rx_rdy_q, armed_q, overrun_q, irq_q;
  logic          push_req, push_ok, push_drop, pop;
  uart_entry_t   wr_entry, head;

  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign rd_valid_o = ~empty_o;
  assign level_o    = level_q;
  assign overrun_o  = overrun_q;
  assign irq_o      = irq_q;

  // armed_q blocks a push until rx_rdy_i has been seen low since reset, so a
  // level held high across reset release is not mistaken for a new character.
  assign push_req  = rx_rdy_i & ~rx_rdy_q & armed_q;
  assign pop       = rd_valid_o & rd_ready_i;
  assign push_ok   = push_req & (~full_o | pop);
  assign push_drop = push_req & full_o & ~pop;

  assign wr_entry = '{err: rx_err_i, data: data_i};

  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .we_i    (push_ok & ~clr_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign rd_data_o = rd_valid_o ? head.data : '0;
  assign rd_err_o  = rd_valid_o ? head.err  : 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rx_rdy_q  <= 1'b0;
      armed_q   <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rx_rdy_q <= rx_rdy_i;
      armed_q  <= armed_q | ~rx_rdy_i;
      irq_q    <= ((level_q >= thresh_i) && (thresh_i != '0)) || overrun_q;
      if (clr_i) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        level_q   <= '0;
        overrun_q <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push_ok && !pop)      level_q <= level_q + 1'b1;
        else if (pop && !push_ok) level_q <= level_q - 1'b1;
        if (push_drop) overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [8:0]    data_i = '0;
  logic          rx_rdy_i = 1'b0, rx_err_i = 1'b0, clr_i = 1'b0, rd_ready_i = 1'b0;
  logic [AW:0]   thresh_i = '0;
  logic          rd_valid_o, rd_err_o, full_o, empty_o, overrun_o, irq_o;
  logic [8:0]    rd_data_o;
  logic [AW:0]   level_o;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb_q [$];

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .rx_rdy_i(rx_rdy_i),
    .rx_err_i(rx_err_i), .clr_i(clr_i), .thresh_i(thresh_i), .rd_ready_i(rd_ready_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_err_o(rd_err_o),
    .level_o(level_o), .full_o(full_o), .empty_o(empty_o),
    .overrun_o(overrun_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted head entry is compared with the oldest expected one.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rd_valid_o && rd_ready_i) begin
        if (sb_q.size() == 0) chk("unexpected_pop", {22'd0, rd_err_o, rd_data_o}, 32'h3ff);
        else chk("pop_entry", {22'd0, rd_err_o, rd_data_o}, {22'd0, sb_q.pop_front()});
      end else if (!rd_valid_o) begin
        chk("idle_data_zero", {22'd0, rd_err_o, rd_data_o}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // One character: one cycle high, one cycle low.
  task automatic push_char(input logic [8:0] d, input logic e);
    data_i = d; rx_err_i = e; rx_rdy_i = 1'b1;
    step();
    rx_rdy_i = 1'b0; rx_err_i = 1'b0;
    step();
  endtask

  task automatic drain();
    rd_ready_i = 1'b1;
    for (int i = 0; i < 40 && !empty_o; i++) step();
    rd_ready_i = 1'b0;
    chk("drain_empty", {31'd0, empty_o}, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_level"},   {27'd0, level_o}, 32'd0);
    chk({tag, "_empty"},   {31'd0, empty_o}, 32'd1);
    chk({tag, "_full"},    {31'd0, full_o}, 32'd0);
    chk({tag, "_valid"},   {31'd0, rd_valid_o}, 32'd0);
    chk({tag, "_data"},    {22'd0, rd_err_o, rd_data_o}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun_o}, 32'd0);
    chk({tag, "_irq"},     {31'd0, irq_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk_reset_outs("rst");
    step();
    rst_ni = 1'b1;
    step(); step();

    // Single pulse: visible the cycle after capture.
    data_i = 9'h041; rx_rdy_i = 1'b1;
    step();
    chk("p1_valid", {31'd0, rd_valid_o}, 32'd1);
    chk("p1_data",  {23'd0, rd_data_o}, 32'h041);
    chk("p1_level", {27'd0, level_o}, 32'd1);
    rx_rdy_i = 1'b0;
    sb_q.push_back(10'h041);
    step();
    drain();

    // Held-high rx_rdy_i yields one entry.
    data_i = 9'h0AA; rx_rdy_i = 1'b1;
    repeat (5) step();
    rx_rdy_i = 1'b0;
    step();
    chk("hold_level", {27'd0, level_o}, 32'd1);
    sb_q.push_back(10'h0AA);
    drain();

    // Simultaneous push and pop with partial occupancy.
    push_char(9'h011, 1'b0); sb_q.push_back(10'h011);
    push_char(9'h012, 1'b1); sb_q.push_back(10'h212);
    data_i = 9'h013; rx_rdy_i = 1'b1; rd_ready_i = 1'b1;
    sb_q.push_back(10'h013);
    step();
    rx_rdy_i = 1'b0; rd_ready_i = 1'b0;
    chk("pp_level", {27'd0, level_o}, 32'd2);
    step();
    drain();

    // Overflow: 17 pushes, the last one dropped.
    for (int i = 0; i < 17; i++) begin
      push_char(9'(i), 1'b0);
      if (i < 16) sb_q.push_back(10'(i));
    end
    chk("ovf_full",    {31'd0, full_o}, 32'd1);
    chk("ovf_level",   {27'd0, level_o}, 32'd16);
    chk("ovf_overrun", {31'd0, overrun_o}, 32'd1);
    chk("ovf_irq",     {31'd0, irq_o}, 32'd1);
    drain();
    chk("ovf_sticky", {31'd0, overrun_o}, 32'd1);
    clr_i = 1'b1; step(); clr_i = 1'b0;
    chk("clr_overrun", {31'd0, overrun_o}, 32'd0);
    step();
    chk("clr_irq", {31'd0, irq_o}, 32'd0);

    // Full with concurrent pop: push accepted, no overrun.
    for (int i = 0; i < 16; i++) begin
      push_char(9'(8'h20 + i), 1'b0);
      sb_q.push_back(10'(8'h20 + i));
    end
    chk("fill_full", {31'd0, full_o}, 32'd1);
    data_i = 9'h155; rx_rdy_i = 1'b1; rd_ready_i = 1'b1;
    sb_q.push_back(10'h155);
    step();
    rx_rdy_i = 1'b0; rd_ready_i = 1'b0;
    chk("fpp_level",   {27'd0, level_o}, 32'd16);
    chk("fpp_overrun", {31'd0, overrun_o}, 32'd0);
    step();
    drain();

    // Watermark and clear-with-push.
    thresh_i = 5'd3;
    push_char(9'h101, 1'b0);
    push_char(9'h102, 1'b0);
    data_i = 9'h103; rx_rdy_i = 1'b1;
    step();
    rx_rdy_i = 1'b0;
    chk("wm_level",   {27'd0, level_o}, 32'd3);
    chk("wm_irq_pre", {31'd0, irq_o}, 32'd0);
    step();
    chk("wm_irq", {31'd0, irq_o}, 32'd1);
    data_i = 9'h1EE; rx_rdy_i = 1'b1; clr_i = 1'b1;
    step();
    rx_rdy_i = 1'b0; clr_i = 1'b0;
    chk("clrp_level", {27'd0, level_o}, 32'd0);
    chk("clrp_empty", {31'd0, empty_o}, 32'd1);
    step();
    chk("clrp_irq", {31'd0, irq_o}, 32'd0);
    thresh_i = '0;

    // Reset mid-stream with rx_rdy_i held high across release.
    push_char(9'h1FF, 1'b1);
    chk("pre_rst_data", {22'd0, rd_err_o, rd_data_o}, 32'h3FF);
    data_i = 9'h0F0; rx_rdy_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    sb_q.delete();
    chk_reset_outs("mid_rst");
    step(); step();
    rst_ni = 1'b1;
    repeat (4) step();
    chk("post_rst_empty", {31'd0, empty_o}, 32'd1);
    chk("post_rst_level", {27'd0, level_o}, 32'd0);
    rx_rdy_i = 1'b0;
    step();
    push_char(9'h033, 1'b0);
    sb_q.push_back(10'h033);
    chk("post_rst_push", {27'd0, level_o}, 32'd1);
    drain();

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
